// File: rtl/xadc_drp_sequencer_if.sv
// XADC DRP read-sequencer bundle: DRP port, trigger/control inputs and
// the per-channel sample outputs consumed downstream.
interface xadc_drp_sequencer_if;
  logic        eoc;
  logic [3:0]  ch_mask;
  logic        err_clr;
  logic        den;
  logic        dwe;
  logic [6:0]  daddr;
  logic        drdy;
  logic [15:0] do_in;
  logic        smp_valid;
  logic [1:0]  smp_ch;
  logic [11:0] smp_data;
  logic [31:0] ch_data;
  logic        err;

  modport master (
    input  eoc, ch_mask, err_clr, drdy, do_in,
    output den, dwe, daddr, smp_valid, smp_ch, smp_data, ch_data, err
  );

  modport slave (
    output eoc, ch_mask, err_clr, drdy, do_in,
    input  den, dwe, daddr, smp_valid, smp_ch, smp_data, ch_data, err
  );
endinterface

// File: rtl/xadc_drp_sequencer.sv
// Round-robin DRP read sequencer: one read per end-of-conversion to the next
// enabled aux channel, with timeout protection and per-channel byte capture.
module xadc_drp_sequencer #(
  parameter logic [6:0] ADDR0   = 7'h1E,
  parameter logic [6:0] ADDR1   = 7'h17,
  parameter logic [6:0] ADDR2   = 7'h1F,
  parameter logic [6:0] ADDR3   = 7'h16,
  parameter int         TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  xadc_drp_sequencer_if.master bus
);

  // state | meaning
  // IDLE  | waiting for eoc with at least one channel enabled
  // ISSUE | den pulse for the selected channel, wait counter cleared
  // WAIT  | daddr held, waiting for drdy or the timeout
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  cur, cur_nxt;
  logic [6:0]  daddr_q, daddr_nxt;
  logic        den_q, den_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        smp_valid_q, smp_valid_nxt;
  logic [1:0]  smp_ch_q, smp_ch_nxt;
  logic [11:0] smp_data_q, smp_data_nxt;
  logic [31:0] ch_data_q, ch_data_nxt;
  logic        err_q, err_nxt;
  logic        done;
  logic        timeout;
  logic [1:0]  sel;
  logic [4:0]  byte_lsb;

  // First enabled channel at or after start, wrapping 3->0; dflt when none.
  function automatic logic [1:0] first_from(input logic [1:0] start,
                                            input logic [3:0] mask,
                                            input logic [1:0] dflt);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] r;
    dbl = {mask, mask} >> start;
    rot = dbl[3:0];
    r   = dflt;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) r = start + 2'(i);
    end
    return r;
  endfunction

  function automatic logic [6:0] addr_of(input logic [1:0] ch);
    logic [6:0] a;
    case (ch)
      2'd0:    a = ADDR0;
      2'd1:    a = ADDR1;
      2'd2:    a = ADDR2;
      default: a = ADDR3;
    endcase
    return a;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= 2'd0;
      daddr_q     <= ADDR0;
      den_q       <= 1'b0;
      cnt         <= 8'd0;
      smp_valid_q <= 1'b0;
      smp_ch_q    <= 2'd0;
      smp_data_q  <= 12'd0;
      ch_data_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur         <= cur_nxt;
      daddr_q     <= daddr_nxt;
      den_q       <= den_nxt;
      cnt         <= cnt_nxt;
      smp_valid_q <= smp_valid_nxt;
      smp_ch_q    <= smp_ch_nxt;
      smp_data_q  <= smp_data_nxt;
      ch_data_q   <= ch_data_nxt;
      err_q       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_nxt       = cur;
    daddr_nxt     = daddr_q;
    den_nxt       = 1'b0;
    cnt_nxt       = cnt;
    smp_valid_nxt = 1'b0;
    smp_ch_nxt    = smp_ch_q;
    smp_data_nxt  = smp_data_q;
    ch_data_nxt   = ch_data_q;
    err_nxt       = err_q;
    done          = 1'b0;
    timeout       = 1'b0;
    sel           = cur;
    byte_lsb      = {cur, 3'b000};

    case (state)
      IDLE: begin
        if (bus.eoc && (bus.ch_mask != 4'd0)) begin
          sel       = first_from(cur, bus.ch_mask, cur);
          cur_nxt   = sel;
          daddr_nxt = addr_of(sel);
          den_nxt   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = 8'd0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.drdy) begin
          smp_valid_nxt                = 1'b1;
          smp_ch_nxt                   = cur;
          smp_data_nxt                 = bus.do_in[15:4];
          ch_data_nxt[byte_lsb +: 8]   = bus.do_in[15:8];
          done                         = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt_nxt == CNT_LAST) begin
            timeout = 1'b1;
            done    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Either exit from WAIT moves the pointer past the channel just read.
    if (done) begin
      cur_nxt   = first_from(cur + 2'd1, bus.ch_mask, cur);
      state_nxt = IDLE;
    end

    if (timeout)          err_nxt = 1'b1;
    else if (bus.err_clr) err_nxt = 1'b0;
  end

  assign bus.den       = den_q;
  assign bus.dwe       = 1'b0;
  assign bus.daddr     = daddr_q;
  assign bus.smp_valid = smp_valid_q;
  assign bus.smp_ch    = smp_ch_q;
  assign bus.smp_data  = smp_data_q;
  assign bus.ch_data   = ch_data_q;
  assign bus.err       = err_q;

endmodule
